// File: rtl/rect_pix_gen.sv
// Rectangle pixel walker for the 96x64 OLED frame buffer.
// Takes two corners and a colour, then walks the rectangle in row-major order
// and emits one linear pixel index per valid/ready handshake.
module rect_pix_gen #(
  parameter int WIDTH   = 96,
  parameter int HEIGHT  = 64,
  parameter int COLOR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         x0,
  input  logic [6:0]         y0,
  input  logic [7:0]         x1,
  input  logic [6:0]         y1,
  input  logic [COLOR_W-1:0] color,
  output logic               busy,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic [12:0]        pixel_index,
  output logic [COLOR_W-1:0] pix_color,
  output logic               done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] XMAX = 8'(WIDTH - 1);
  localparam logic [6:0] YMAX = 7'(HEIGHT - 1);

  // Shift-add form of y*96 + x; the walker never needs a multiplier.
  function automatic logic [12:0] idx_f(input logic [7:0] x, input logic [6:0] y);
    logic [12:0] yw;
    yw = {6'd0, y};
    return (yw << 6) + (yw << 5) + {5'd0, x};
  endfunction

  state_t               state_q, state_d;
  logic [7:0]           xl_q, xl_d, xr_q, xr_d, cur_x_q, cur_x_d;
  logic [6:0]           yb_q, yb_d, cur_y_q, cur_y_d;
  logic [COLOR_W-1:0]   color_q, color_d;
  logic [12:0]          pixel_index_q, pixel_index_d;
  logic                 busy_q, busy_d, pix_valid_q, pix_valid_d, done_q, done_d;

  logic [7:0]           cx0_s, cx1_s, xl_s, xr_s;
  logic [6:0]           cy0_s, cy1_s, yt_s, yb_s;

  // Clamp incoming corners to the screen, then order them.
  always_comb begin
    cx0_s = (x0 > XMAX) ? XMAX : x0;
    cx1_s = (x1 > XMAX) ? XMAX : x1;
    cy0_s = (y0 > YMAX) ? YMAX : y0;
    cy1_s = (y1 > YMAX) ? YMAX : y1;
    xl_s  = (cx0_s < cx1_s) ? cx0_s : cx1_s;
    xr_s  = (cx0_s < cx1_s) ? cx1_s : cx0_s;
    yt_s  = (cy0_s < cy1_s) ? cy0_s : cy1_s;
    yb_s  = (cy0_s < cy1_s) ? cy1_s : cy0_s;
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d       = state_q;
    xl_d          = xl_q;
    xr_d          = xr_q;
    yb_d          = yb_q;
    cur_x_d       = cur_x_q;
    cur_y_d       = cur_y_q;
    color_d       = color_q;
    pixel_index_d = pixel_index_q;
    busy_d        = busy_q;
    pix_valid_d   = pix_valid_q;
    done_d        = 1'b0;
    case (state_q)
      IDLE: begin
        busy_d      = 1'b0;
        pix_valid_d = 1'b0;
        if (start) begin
          xl_d          = xl_s;
          xr_d          = xr_s;
          yb_d          = yb_s;
          cur_x_d       = xl_s;
          cur_y_d       = yt_s;
          color_d       = color;
          pixel_index_d = idx_f(xl_s, yt_s);
          busy_d        = 1'b1;
          pix_valid_d   = 1'b1;
          state_d       = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (pix_valid_q && pix_ready) begin
          if (cur_x_q < xr_q) begin
            cur_x_d       = cur_x_q + 8'd1;
            pixel_index_d = idx_f(cur_x_q + 8'd1, cur_y_q);
          end else if (cur_y_q < yb_q) begin
            cur_x_d       = xl_q;
            cur_y_d       = cur_y_q + 7'd1;
            pixel_index_d = idx_f(xl_q, cur_y_q + 7'd1);
          end else begin
            pix_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        busy_d      = 1'b0;
        pix_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        busy_d      = 1'b0;
        pix_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      xl_q          <= 8'd0;
      xr_q          <= 8'd0;
      yb_q          <= 7'd0;
      cur_x_q       <= 8'd0;
      cur_y_q       <= 7'd0;
      color_q       <= '0;
      pixel_index_q <= 13'd0;
      busy_q        <= 1'b0;
      pix_valid_q   <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      xl_q          <= xl_d;
      xr_q          <= xr_d;
      yb_q          <= yb_d;
      cur_x_q       <= cur_x_d;
      cur_y_q       <= cur_y_d;
      color_q       <= color_d;
      pixel_index_q <= pixel_index_d;
      busy_q        <= busy_d;
      pix_valid_q   <= pix_valid_d;
      done_q        <= done_d;
    end
  end

  assign busy        = busy_q;
  assign pix_valid   = pix_valid_q;
  assign pixel_index = pixel_index_q;
  assign pix_color   = color_q;
  assign done        = done_q;

endmodule
